// File: rtl/vip_ctrl_inserter_if.sv
// Avalon-ST video beat bundle: the source drives data/valid/sop/eop, the sink drives ready.
interface vip_ctrl_inserter_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/vip_ctrl_inserter.sv
// Raw-to-Avalon-ST-Video bridge: puts a control packet and a data-packet header
// in front of every raw frame, then passes the frame pixels straight through.
module vip_ctrl_inserter #(
  parameter int DATA_WIDTH   = 24,
  parameter int COLOR_BITS   = 8,
  parameter int COLOR_PLANES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  vip_ctrl_inserter_if.slave  din,
  vip_ctrl_inserter_if.master dout,
  input  logic [15:0]         im_width,
  input  logic [15:0]         im_height,
  input  logic [3:0]          im_interlaced
);
  localparam int N = (9 + COLOR_PLANES - 1) / COLOR_PLANES;

  typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_BODY, DATA_HDR, DATA} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [35:0]             ctrl;
  logic [47:0]             str;
  logic [DATA_WIDTH-1:0]   body;

  // Pad the nibble string so a partially filled last beat reads zeros.
  assign str = {ctrl, 12'h000};

  always_comb begin
    body = '0;
    for (int k = 0; k < COLOR_PLANES; k++)
      body[k*COLOR_BITS +: 4] = 4'(str >> (44 - 4*(int'(cnt)*COLOR_PLANES + k)));
  end

  always_comb begin
    dout.valid         = 1'b0;
    dout.startofpacket = 1'b0;
    dout.endofpacket   = 1'b0;
    dout.data          = '0;
    din.ready          = 1'b0;
    unique case (state)
      // sop beat is held back until the headers are out; stray beats are dropped
      IDLE:      din.ready = din.valid & ~din.startofpacket;
      CTRL_HDR: begin
        dout.valid         = 1'b1;
        dout.startofpacket = 1'b1;
        dout.data[3:0]     = 4'hF;
      end
      CTRL_BODY: begin
        dout.valid       = 1'b1;
        dout.data        = body;
        dout.endofpacket = (cnt == 4'(N-1));
      end
      DATA_HDR: begin
        dout.valid         = 1'b1;
        dout.startofpacket = 1'b1;
      end
      DATA: begin
        dout.data        = din.data;
        dout.valid       = din.valid;
        dout.endofpacket = din.endofpacket;
        din.ready        = dout.ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ctrl  <= '0;
    end else begin
      unique case (state)
        IDLE: if (din.valid && din.startofpacket) begin
          ctrl  <= {im_width, im_height, im_interlaced};
          state <= CTRL_HDR;
        end
        CTRL_HDR: if (dout.ready) begin
          cnt   <= '0;
          state <= CTRL_BODY;
        end
        CTRL_BODY: if (dout.ready) begin
          if (cnt == 4'(N-1)) begin
            cnt   <= '0;
            state <= DATA_HDR;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DATA_HDR: if (dout.ready) state <= DATA;
        DATA:     if (din.valid && dout.ready && din.endofpacket) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vip_ctrl_inserter.sv
// Self-checking bench: directed cases plus random frames against a beat-list model.
module tb_vip_ctrl_inserter;
  typedef struct packed { logic [23:0] d; logic s; logic e; } beat_t;

  logic clk, rst_n;
  logic [15:0] im_width, im_height;
  logic [3:0]  im_interlaced;
  int checks = 0, failures = 0, cyc = 0;
  bit rand_rdy = 0;

  beat_t exp_q[$], got_q[$];
  int    got_c[$];
  bit    stalled = 0;
  beat_t held;
  logic [7:0] e2 [12];

  vip_ctrl_inserter_if #(.DATA_WIDTH(24)) din ();
  vip_ctrl_inserter_if #(.DATA_WIDTH(24)) dout ();
  vip_ctrl_inserter_if #(.DATA_WIDTH(8))  d1i ();
  vip_ctrl_inserter_if #(.DATA_WIDTH(8))  d1o ();

  vip_ctrl_inserter #(.DATA_WIDTH(24), .COLOR_BITS(8), .COLOR_PLANES(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din.slave), .dout(dout.master),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced));

  vip_ctrl_inserter #(.DATA_WIDTH(8), .COLOR_BITS(8), .COLOR_PLANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(d1i.slave), .dout(d1o.master),
    .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(posedge clk); #1;
    dout.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Collects transferred beats and checks the output is frozen while stalled.
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled)
        chk("stall_hold", 64'({dout.valid, dout.data, dout.startofpacket, dout.endofpacket}),
            64'({1'b1, held}));
      if (dout.valid && dout.ready) begin
        got_q.push_back({dout.data, dout.startofpacket, dout.endofpacket});
        got_c.push_back(cyc);
      end
      stalled = dout.valid && !dout.ready;
      held    = {dout.data, dout.startofpacket, dout.endofpacket};
    end
  end

  // Model: control packet is the nibble string {w,h,il}, three nibbles per beat,
  // nibble k of a beat in byte k; then a type-0 header.
  task automatic push_ctrl(logic [15:0] w, logic [15:0] h, logic [3:0] il);
    logic [35:0] s;
    logic [23:0] d;
    int idx;
    s = {w, h, il};
    exp_q.push_back({24'h00000F, 1'b1, 1'b0});
    for (int b = 0; b < 3; b++) begin
      d = 0;
      for (int k = 0; k < 3; k++) begin
        idx = b*3 + k;
        d = d | (24'((s >> (32 - 4*idx)) & 36'hF) << (8*k));
      end
      exp_q.push_back({d, 1'b0, b == 2});
    end
    exp_q.push_back({24'h000000, 1'b1, 1'b0});
  endtask

  task automatic wait_ready();
    int t = 0;
    do begin @(negedge clk); t++; end while (!din.ready && t < 400);
    if (!din.ready) chk("din_ready_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_frame(int n, logic [15:0] w, logic [15:0] h, logic [3:0] il,
                            bit gaps, bit use_model);
    logic [23:0] px;
    if (use_model) push_ctrl(w, h, il);
    im_width = w; im_height = h; im_interlaced = il;
    for (int i = 0; i < n; i++) begin
      px = 24'($urandom);
      if (gaps) begin
        din.valid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      din.valid = 1; din.data = px;
      din.startofpacket = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      din.endofpacket = (i == n-1);
      exp_q.push_back({px, 1'b0, i == n-1});
      if (i == 0) begin
        @(posedge clk); #1;
        im_width = 16'($urandom); im_height = 16'($urandom); im_interlaced = 4'($urandom);
      end
      wait_ready();
    end
    din.valid = 0; din.startofpacket = 0; din.endofpacket = 0;
  endtask

  task automatic check_frame(string tag);
    beat_t g, e;
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 500) begin @(negedge clk); t++; end
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_c.pop_front());
      chk({tag, "_beat"}, 64'(g), 64'(e));
    end
    repeat (3) @(negedge clk);
    chk({tag, "_extra"}, 64'(got_q.size()), 64'(0));
    exp_q.delete(); got_q.delete(); got_c.delete();
  endtask

  task automatic reset_mid(bit in_data);
    rand_rdy = 0;
    repeat (2) @(posedge clk); #1;
    im_width = 16'd8; im_height = 16'd4; im_interlaced = 4'd0;
    din.valid = 1; din.startofpacket = 1; din.endofpacket = 0; din.data = 24'h123456;
    if (!in_data) begin repeat (3) @(posedge clk); #1; end
    else begin wait_ready(); din.startofpacket = 0; din.data = 24'h654321; end
    chk("pre_rst_valid", 64'(dout.valid), 64'(1));
    rst_n = 0; #1;
    chk("rst_dout_valid", 64'(dout.valid), 64'(0));
    chk("rst_dout_sop", 64'(dout.startofpacket), 64'(0));
    din.valid = 0; din.startofpacket = 0;
    @(posedge clk); #1; rst_n = 1;
    exp_q.delete(); got_q.delete(); got_c.delete();
  endtask

  initial begin
    int t0, n;
    e2 = '{8'h0F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h06, 8'h03, 8'h00, 8'hAB};
    rst_n = 0; im_width = 0; im_height = 0; im_interlaced = 0;
    din.valid = 0; din.data = 0; din.startofpacket = 0; din.endofpacket = 0;
    d1i.valid = 0; d1i.data = 0; d1i.startofpacket = 0; d1i.endofpacket = 0;
    d1o.ready = 1; dout.ready = 1;
    #12;
    chk("reset_dout_valid", 64'(dout.valid), 64'(0));
    chk("reset_dout_data", 64'(dout.data), 64'(0));
    chk("reset_dout_sop_eop", 64'({dout.startofpacket, dout.endofpacket}), 64'(0));
    chk("reset_din_ready", 64'(din.ready), 64'(0));
    @(posedge clk); #1; rst_n = 1;

    // One plane per beat: ten control beats, header, single pixel.
    @(posedge clk); #1;
    im_width = 16'h0123; im_height = 16'h0456; im_interlaced = 4'h3;
    d1i.valid = 1; d1i.startofpacket = 1; d1i.endofpacket = 1; d1i.data = 8'hAB;
    @(negedge clk);
    chk("p1_idle_valid", 64'(d1o.valid), 64'(0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("p1_beat", 64'({d1o.valid, d1o.data, d1o.startofpacket, d1o.endofpacket}),
          64'({1'b1, e2[i], i == 0 || i == 10, i == 9 || i == 11}));
    end
    @(posedge clk); #1; d1i.valid = 0;
    @(negedge clk);
    chk("p1_back_idle", 64'(d1o.valid), 64'(0));

    // 640x480 progressive with literal expected beats and latency.
    @(posedge clk); #1;
    exp_q.push_back({24'h00000F, 1'b1, 1'b0});
    exp_q.push_back({24'h080200, 1'b0, 1'b0});
    exp_q.push_back({24'h010000, 1'b0, 1'b0});
    exp_q.push_back({24'h00000E, 1'b0, 1'b1});
    exp_q.push_back({24'h000000, 1'b1, 1'b0});
    t0 = cyc;
    send_frame(3, 16'd640, 16'd480, 4'd0, 0, 0);
    chk("lat_ctrl_hdr", 64'(got_c[0] - t0), 64'(1));
    chk("lat_first_pixel", 64'(got_c[5] - got_c[0]), 64'(5));
    check_frame("f640");

    // Stray beats in IDLE are swallowed.
    for (int i = 0; i < 4; i++) begin
      din.valid = 1; din.startofpacket = 0; din.endofpacket = (i == 3); din.data = 24'($urandom);
      @(negedge clk);
      chk("stray_ready", 64'(din.ready), 64'(1));
      chk("stray_no_out", 64'(dout.valid), 64'(0));
      @(posedge clk); #1;
    end
    din.valid = 0; din.endofpacket = 0;
    check_frame("stray");

    send_frame(1, 16'h1234, 16'h5678, 4'h9, 0, 1);
    check_frame("single");

    rand_rdy = 1;
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, 6));
      send_frame(n, 16'($urandom), 16'($urandom), 4'($urandom), 1, 1);
      check_frame("rand");
    end

    reset_mid(0);
    send_frame(2, 16'd320, 16'd240, 4'h1, 0, 1);
    check_frame("after_rst_ctrl");
    reset_mid(1);
    rand_rdy = 1;
    send_frame(3, 16'hBEEF, 16'h0042, 4'hA, 1, 1);
    check_frame("after_rst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
